fp_sequencer: RTL and testbench
===============================

Name: fp_sequencer

Overview:
- Sequences the forward-propagation MAC datapath for the two-layer network (input -> hidden -> output).
- Started by the control unit's do_fp level; walks every neuron of each layer and issues weight-memory addresses and input indices.
- Drives accumulator clear/enable and activation-writeback strobes.
- Returns a one-cycle fp_done pulse to the control unit when the output layer is written.

Parameters:
- N_IN, 784, input-layer fan-in (pixels); N_IN >= N_HID required
- N_HID, 30, hidden neurons; N_HID >= N_OUT required
- N_OUT, 10, output neurons
- MEM_LAT, 1, weight/input read latency in cycles, >= 1
- Derived: AW = $clog2(N_IN*N_HID + N_HID*N_OUT); XW = $clog2(N_IN); NW = $clog2(N_HID)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- do_fp  in  1  forward-pass request level from control unit
- hold  in  1  stall address issue (memory/port busy)
- fp_done  out  1  one-cycle pulse, pass complete
- busy  out  1  high in any state except IDLE
- w_addr  out  AW  weight memory address
- x_idx  out  XW  activation/pixel index for current operand
- layer  out  1  0 = hidden layer, 1 = output layer
- mac_clr  out  1  clear accumulator at next edge
- mac_en  out  1  accumulate data returning this cycle
- act_we  out  1  write activation of current neuron
- act_idx  out  NW  neuron index being written

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high. On rst, state = IDLE and all outputs, counters and the valid pipe are 0. rst overrides everything, including mid-pass; the next pass restarts at w_addr 0.
- States: IDLE, ISSUE, DRAIN, WRITE, DONE.
- IDLE:
  - do_fp = 1 -> mac_clr = 1 this cycle; clear layer, neuron counter, k and address counter; go to ISSUE.
  - do_fp = 0 -> stay in IDLE.
- ISSUE:
  - hold = 0: present w_addr = addr counter and x_idx = k; push 1 into the valid pipe; addr++ and k++.
  - When k == fan_in - 1 at issue, go to DRAIN (fan_in = N_IN for layer 0, N_HID for layer 1).
  - hold = 1: push 0 into the valid pipe; counters frozen; w_addr/x_idx hold their values.
- Valid pipe: MEM_LAT-deep shift register; mac_en = pipe output, i.e. exactly MEM_LAT cycles after the issue cycle. The pipe keeps shifting during hold.
- DRAIN:
  - Lasts exactly MEM_LAT cycles; hold is ignored.
  - The last mac_en of the neuron occurs in the final DRAIN cycle; then go to WRITE.
- WRITE:
  - act_we = 1 and act_idx = neuron for one cycle.
  - If neuron is not last: mac_clr = 1, neuron++, k = 0, go to ISSUE.
  - If last neuron of layer 0: mac_clr = 1, layer = 1, neuron = 0, k = 0, go to ISSUE.
  - If last neuron of layer 1: go to DONE.
  - mac_clr and act_we may coincide; the clear takes effect at the following edge.
- Weight addressing:
  - Layout is neuron-major and contiguous: layer 1 starts at N_IN*N_HID.
  - w_addr is a running counter 0 .. N_IN*N_HID + N_HID*N_OUT - 1, each value issued exactly once per pass; no multiplier.
- DONE: fp_done = 1 for one cycle, then IDLE. If do_fp is still high in IDLE, a new pass starts (the control unit drops do_fp on fp_done).
- do_fp deasserting mid-pass is ignored; the pass completes. Exception: see Optional Feature.
- Pass length with hold never asserted: 2 + N_HID*(N_IN+MEM_LAT+1) + N_OUT*(N_HID+MEM_LAT+1) cycles, counted from the IDLE cycle accepting do_fp through DONE. Each held ISSUE cycle adds 1.
- Outputs when not meaningful: w_addr/x_idx are don't-care outside ISSUE; act_idx is don't-care outside WRITE.

Optional Feature:
- Macro: FP_ABORT_EN.
- Defined: do_fp = 0 sampled in ISSUE, DRAIN or WRITE -> next state IDLE. That cycle: mac_clr = 1, valid pipe flushed, no act_we, no fp_done. The next request restarts at w_addr 0.
- Undefined: do_fp is only sampled in IDLE and passes always run to completion.

Test Plan:
- Baseline pass: N_IN=4, N_HID=3, N_OUT=2, MEM_LAT=1; do_fp high at cycle 0 -> fp_done pulses exactly at cycle 29; 18 mac_en pulses; w_addr sequence 0..17 in order; 5 act_we pulses with act_idx 0,1,2 (layer 0) then 0,1 (layer 1).
- Stall: same config, hold high for 3 cycles during hidden neuron 1 issue -> fp_done at cycle 32; w_addr sequence unchanged; mac_en shows a 3-cycle gap.
- Latency: MEM_LAT=3 -> each mac_en trails its w_addr issue by 3 cycles; DRAIN lasts 3 cycles; fp_done at cycle 2+3*8+2*7-1 = 39.
- Mid-pass reset: rst asserted at cycle 10 -> cycle 11 busy=0 and all outputs 0; a new do_fp -> w_addr restarts at 0 and the full 30-cycle pass completes.
- Back-to-back: do_fp held high through fp_done -> busy drops for one cycle in IDLE; the second pass also completes in 30 cycles.
- FP_ABORT_EN defined: do_fp dropped at cycle 8 -> cycle 9 IDLE, mac_clr pulsed at cycle 8, no fp_done; without the macro the same stimulus still gives fp_done at cycle 29.

Source files
------------

// File: rtl/fp_sequencer.sv
// fp_sequencer: walks the hidden layer and then the output layer of a
// two-layer network. It issues one weight address and one operand index per
// cycle, delays a valid flag by the memory latency to drive mac_en, and
// strobes the activation write at the end of each neuron.
//
// Optional build macro FP_ABORT_EN: when defined, dropping do_fp during
// ISSUE, DRAIN or WRITE abandons the pass. The accumulator is cleared, the
// valid pipe is flushed and the sequencer returns to IDLE without an
// activation write or fp_done. When undefined, do_fp is sampled only in IDLE
// and every pass runs to completion.
//
// Handshake: do_fp is a request level that is accepted in IDLE. fp_done is a
// single-cycle completion pulse. hold is a stall that freezes address issue
// in ISSUE; the valid pipe keeps shifting while hold is high.
module fp_sequencer #(
  parameter int N_IN    = 784,
  parameter int N_HID   = 30,
  parameter int N_OUT   = 10,
  parameter int MEM_LAT = 1,
  localparam int AW = $clog2(N_IN*N_HID + N_HID*N_OUT),
  localparam int XW = $clog2(N_IN),
  localparam int NW = $clog2(N_HID)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          do_fp,
  input  logic          hold,
  output logic          fp_done,
  output logic          busy,
  output logic [AW-1:0] w_addr,
  output logic [XW-1:0] x_idx,
  output logic          layer,
  output logic          mac_clr,
  output logic          mac_en,
  output logic          act_we,
  output logic [NW-1:0] act_idx
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ISSUE = 3'd1;
  localparam logic [2:0] DRAIN = 3'd2;
  localparam logic [2:0] WRITE = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  // Drain counter needs at least one bit even when MEM_LAT is 1.
  localparam int DW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [DW-1:0] D_LAST = DW'(MEM_LAT - 1);

  // Last operand index per layer (fan-in minus one) and last neuron per layer.
  localparam logic [XW-1:0] K_LAST0 = XW'(N_IN - 1);
  localparam logic [XW-1:0] K_LAST1 = XW'(N_HID - 1);
  localparam logic [NW-1:0] N_LAST0 = NW'(N_HID - 1);
  localparam logic [NW-1:0] N_LAST1 = NW'(N_OUT - 1);

  logic [2:0]         state;
  logic [DW-1:0]      dcnt;
  logic [MEM_LAT-1:0] vpipe;
  logic               abort;
  logic               issue;
  logic               last_k;
  logic               last_n;
  logic               last_all;

`ifdef FP_ABORT_EN
  assign abort = !do_fp && ((state == ISSUE) || (state == DRAIN) || (state == WRITE));
`else
  assign abort = 1'b0;
`endif

  assign issue    = (state == ISSUE) && !hold && !abort;
  assign last_k   = (x_idx == (layer ? K_LAST1 : K_LAST0));
  assign last_n   = (act_idx == (layer ? N_LAST1 : N_LAST0));
  assign last_all = layer && last_n;

  assign busy    = (state != IDLE);
  assign fp_done = (state == DONE);
  assign act_we  = (state == WRITE) && !abort;
  assign mac_en  = vpipe[MEM_LAT-1];
  // Clear on pass start, between neurons (the clear lands after the write),
  // and when a pass is abandoned.
  assign mac_clr = ((state == IDLE) && do_fp)
                 || ((state == WRITE) && !last_all)
                 || abort;

  // Main sequencer: state, running weight address, operand index, neuron and layer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      dcnt    <= '0;
      w_addr  <= '0;
      x_idx   <= '0;
      act_idx <= '0;
      layer   <= 1'b0;
    end else if (abort) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (do_fp) begin
            state   <= ISSUE;
            w_addr  <= '0;
            x_idx   <= '0;
            act_idx <= '0;
            layer   <= 1'b0;
          end
        end
        ISSUE: begin
          if (!hold) begin
            w_addr <= w_addr + 1'b1;
            x_idx  <= x_idx + 1'b1;
            if (last_k) begin
              state <= DRAIN;
              dcnt  <= '0;
            end
          end
        end
        DRAIN: begin
          if (dcnt == D_LAST) begin
            state <= WRITE;
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
        WRITE: begin
          x_idx <= '0;
          if (!last_n) begin
            act_idx <= act_idx + 1'b1;
            state   <= ISSUE;
          end else if (!layer) begin
            layer   <= 1'b1;
            act_idx <= '0;
            state   <= ISSUE;
          end else begin
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Valid pipe: a 1 enters on each real issue and emerges MEM_LAT cycles later.
  always_ff @(posedge clk) begin
    if (rst || abort) begin
      vpipe <= '0;
    end else begin
      vpipe <= MEM_LAT'({vpipe, issue});
    end
  end

endmodule

// File: tb/tb_fp_sequencer.sv
// Bench for fp_sequencer with a small network (4-3-2). Instance a uses
// MEM_LAT=1 and instance b uses MEM_LAT=3. Expected addresses, activation
// writes and fp_done cycles are queued when a pass is started and are
// consumed by a negedge monitor as the DUT produces them.
module tb_fp_sequencer;

  localparam int N_IN  = 4;
  localparam int N_HID = 3;
  localparam int N_OUT = 2;
  localparam int AW = $clog2(N_IN*N_HID + N_HID*N_OUT);
  localparam int XW = $clog2(N_IN);
  localparam int NW = $clog2(N_HID);
  localparam int N_W = N_IN*N_HID + N_HID*N_OUT;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic rst, do_fp_a, hold_a, do_fp_b, hold_b;

  logic          done_a, busy_a, layer_a, mac_clr_a, mac_en_a, act_we_a;
  logic [AW-1:0] w_addr_a;
  logic [XW-1:0] x_idx_a;
  logic [NW-1:0] act_idx_a;

  logic          done_b, busy_b, layer_b, mac_clr_b, mac_en_b, act_we_b;
  logic [AW-1:0] w_addr_b;
  logic [XW-1:0] x_idx_b;
  logic [NW-1:0] act_idx_b;

  fp_sequencer #(.N_IN(N_IN), .N_HID(N_HID), .N_OUT(N_OUT), .MEM_LAT(1)) u_dut_a (
    .clk(clk), .rst(rst), .do_fp(do_fp_a), .hold(hold_a),
    .fp_done(done_a), .busy(busy_a), .w_addr(w_addr_a), .x_idx(x_idx_a),
    .layer(layer_a), .mac_clr(mac_clr_a), .mac_en(mac_en_a),
    .act_we(act_we_a), .act_idx(act_idx_a)
  );

  fp_sequencer #(.N_IN(N_IN), .N_HID(N_HID), .N_OUT(N_OUT), .MEM_LAT(3)) u_dut_b (
    .clk(clk), .rst(rst), .do_fp(do_fp_b), .hold(hold_b),
    .fp_done(done_b), .busy(busy_b), .w_addr(w_addr_b), .x_idx(x_idx_b),
    .layer(layer_b), .mac_clr(mac_clr_b), .mac_en(mac_en_b),
    .act_we(act_we_b), .act_idx(act_idx_b)
  );

  // scoreboard
  int total = 0;
  int bad = 0;
  logic [AW-1:0] exp_q[$];
  logic [NW:0]   act_q[$];
  int            done_q[$];
  logic [AW-1:0] exp_qb[$];
  int            done_qb[$];
  int done_cnt_a = 0;
  int done_cnt_b = 0;
  int t0_a;
  int t0_b;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int x_of(input int a);
    if (a < N_IN*N_HID) return a % N_IN;
    return (a - N_IN*N_HID) % N_HID;
  endfunction

  task automatic push_addrs(input int first, input int last_excl);
    for (int a = first; a < last_excl; a++) exp_q.push_back(AW'(a));
  endtask

  task automatic push_pass_a(input int t0, input int extra);
    push_addrs(0, N_W);
    for (int n = 0; n < N_HID; n++) act_q.push_back({1'b0, NW'(n)});
    for (int n = 0; n < N_OUT; n++) act_q.push_back({1'b1, NW'(n)});
    done_q.push_back(t0 + 29 + extra);
  endtask

  // monitor: compares DUT outputs against the queues away from the active edge
  logic [AW+XW-1:0] ha [0:3] = '{default: '0};
  logic [AW+XW-1:0] hb [0:3] = '{default: '0};
  logic [AW-1:0]    e;
  logic [NW:0]      ea;

  always @(negedge clk) begin
    if (mac_en_a) begin
      if (exp_q.size() == 0) check("mac_en_a_unexpected", mac_en_a, 0);
      else begin
        e = exp_q.pop_front();
        check("w_addr_a", ha[0][AW-1:0], e);
        check("x_idx_a", ha[0][AW+XW-1:AW], x_of(int'(e)));
      end
    end
    if (act_we_a) begin
      if (act_q.size() == 0) check("act_we_a_unexpected", act_we_a, 0);
      else begin
        ea = act_q.pop_front();
        check("act_idx_a", act_idx_a, ea[NW-1:0]);
        check("layer_a", layer_a, ea[NW]);
        check("mac_clr_at_write_a", mac_clr_a,
              !(ea[NW] && (ea[NW-1:0] == NW'(N_OUT-1))));
      end
    end
    if (done_a) begin
      done_cnt_a++;
      if (done_q.size() == 0) check("fp_done_a_unexpected", done_a, 0);
      else check("fp_done_cycle_a", cyc, done_q.pop_front());
      check("busy_at_done_a", busy_a, 1);
    end
    if (mac_en_b) begin
      if (exp_qb.size() == 0) check("mac_en_b_unexpected", mac_en_b, 0);
      else begin
        e = exp_qb.pop_front();
        check("w_addr_b", hb[2][AW-1:0], e);
        check("x_idx_b", hb[2][AW+XW-1:AW], x_of(int'(e)));
      end
    end
    if (done_b) begin
      done_cnt_b++;
      if (done_qb.size() == 0) check("fp_done_b_unexpected", done_b, 0);
      else check("fp_done_cycle_b", cyc, done_qb.pop_front());
    end
    ha[3] <= ha[2]; ha[2] <= ha[1]; ha[1] <= ha[0]; ha[0] <= {x_idx_a, w_addr_a};
    hb[3] <= hb[2]; hb[2] <= hb[1]; hb[1] <= hb[0]; hb[0] <= {x_idx_b, w_addr_b};
  end

  // driver tasks
  task automatic to_cycle(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_a(input int extra, input int passes);
    @(posedge clk);
    #1;
    t0_a = cyc;
    for (int p = 0; p < passes; p++) push_pass_a(t0_a + 30*p, extra);
    do_fp_a = 1'b1;
    #1;
    check("mac_clr_start_a", mac_clr_a, 1);
  endtask

  task automatic wait_done_a(input int budget, input bit drop);
    int prev = done_cnt_a;
    int n = 0;
    while (done_cnt_a == prev && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("fp_done_seen_a", done_cnt_a - prev, 1);
    if (drop) do_fp_a = 1'b0;
  endtask

  task automatic check_drained_a(input string tag);
    check({tag, "_addr_q_left"}, exp_q.size(), 0);
    check({tag, "_act_q_left"}, act_q.size(), 0);
    check({tag, "_done_q_left"}, done_q.size(), 0);
  endtask

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  // directed sequence
  initial begin
    int prev;
    rst = 1'b1; do_fp_a = 1'b0; hold_a = 1'b0; do_fp_b = 1'b0; hold_b = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("reset_busy_a", busy_a, 0);
    check("reset_done_a", done_a, 0);
    check("reset_mac_en_a", mac_en_a, 0);
    check("reset_mac_clr_a", mac_clr_a, 0);
    check("reset_act_we_a", act_we_a, 0);
    check("reset_w_addr_a", w_addr_a, 0);
    check("reset_layer_a", layer_a, 0);
    check("reset_busy_b", busy_b, 0);

    // baseline pass: fp_done at cycle 29
    start_a(0, 1);
    wait_done_a(100, 1);
    check("base_busy_after", busy_a, 0);
    check_drained_a("base");

    // stall: hold for 3 cycles in hidden neuron 1, fp_done at cycle 32
    start_a(3, 1);
    to_cycle(t0_a + 8);
    hold_a = 1'b1;
    to_cycle(t0_a + 9);
    check("stall_gap0", mac_en_a, 0);
    to_cycle(t0_a + 10);
    check("stall_gap1", mac_en_a, 0);
    to_cycle(t0_a + 11);
    check("stall_gap2", mac_en_a, 0);
    hold_a = 1'b0;
    to_cycle(t0_a + 12);
    check("stall_resume", mac_en_a, 1);
    wait_done_a(100, 1);
    check_drained_a("stall");

    // latency 3 on instance b: fp_done at cycle 39
    @(posedge clk);
    #1;
    t0_b = cyc;
    for (int a = 0; a < N_W; a++) exp_qb.push_back(AW'(a));
    done_qb.push_back(t0_b + 39);
    do_fp_b = 1'b1;
    prev = done_cnt_b;
    for (int n = 0; n < 100 && done_cnt_b == prev; n++) begin
      @(posedge clk);
      #1;
    end
    check("fp_done_seen_b", done_cnt_b - prev, 1);
    do_fp_b = 1'b0;
    check("lat_addr_q_left", exp_qb.size(), 0);
    check("lat_done_q_left", done_qb.size(), 0);

    // mid-pass reset at cycle 10, then a full fresh pass
    start_a(0, 1);
    to_cycle(t0_a + 10);
    rst = 1'b1;
    to_cycle(t0_a + 11);
    rst = 1'b0;
    do_fp_a = 1'b0;
    exp_q.delete(); act_q.delete(); done_q.delete();
    #1;
    check("rst_busy", busy_a, 0);
    check("rst_w_addr", w_addr_a, 0);
    check("rst_x_idx", x_idx_a, 0);
    check("rst_layer", layer_a, 0);
    check("rst_mac_en", mac_en_a, 0);
    check("rst_mac_clr", mac_clr_a, 0);
    check("rst_act_we", act_we_a, 0);
    check("rst_act_idx", act_idx_a, 0);
    check("rst_done", done_a, 0);
    start_a(0, 1);
    wait_done_a(100, 1);
    check_drained_a("after_rst");

    // back-to-back: do_fp held through fp_done
    start_a(0, 2);
    wait_done_a(100, 0);
    check("b2b_busy_gap", busy_a, 0);
    check("b2b_restart_clr", mac_clr_a, 1);
    to_cycle(t0_a + 31);
    check("b2b_busy_again", busy_a, 1);
    wait_done_a(100, 1);
    check_drained_a("b2b");

    // do_fp dropped at cycle 8
    @(posedge clk);
    #1;
    t0_a = cyc;
`ifdef FP_ABORT_EN
    push_addrs(0, 5);
    act_q.push_back({1'b0, NW'(0)});
`else
    push_pass_a(t0_a, 0);
`endif
    do_fp_a = 1'b1;
    to_cycle(t0_a + 8);
    do_fp_a = 1'b0;
    #1;
`ifdef FP_ABORT_EN
    check("abort_mac_clr", mac_clr_a, 1);
    check("abort_no_we", act_we_a, 0);
    to_cycle(t0_a + 9);
    check("abort_idle", busy_a, 0);
    prev = done_cnt_a;
    repeat (40) @(posedge clk);
    #1;
    check("abort_no_done", done_cnt_a, prev);
    check_drained_a("abort");
    start_a(0, 1);
    wait_done_a(100, 1);
    check_drained_a("after_abort");
`else
    check("drop_ignored_busy", busy_a, 1);
    wait_done_a(100, 1);
    check_drained_a("drop_ignored");
`endif

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
